// File: rtl/rand_check.sv
// Receiving-end checker for the 20-bit, 2-bit-per-step game LFSR: rebuilds the
// generator state from 9-bit window samples, then predicts and scores each later sample.
module rand_check #(
    parameter int LOSS_THRESH = 3,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [8:0]       in_num,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             mismatch,
    output logic [8:0]       pred_num,
    output logic [ERR_W-1:0] err_cnt
);

    // in_valid qualifies in_num for exactly one generator step; there is no
    // ready because the checker accepts every valid sample, and with in_valid=0
    // nothing advances (the generator is assumed to hold too).

    typedef enum logic {ACQ, LOCKED} state_t;

    localparam logic [2:0] LOSS = 3'(LOSS_THRESH);

    state_t          state;
    logic [2:0]      acq_cnt;
    logic [2:0]      miss_run;
    logic [19:0]     shadow;
    logic [5:0][8:0] win_sr;

    logic [19:0] s0;
    logic [19:0] s7;
    logic [19:0] shadow_nxt;
    logic [2:0]  miss_nxt;
    logic        overlap_ok;

    function automatic logic [19:0] lfsr_step(input logic [19:0] s);
        return {s[9] ^ s[3], s[11] ^ s[2], s[19:2]};
    endfunction

    // win_sr[0] is the newest stored window; with 6 stored plus the current
    // sample, win_sr[5] is w0 and in_num is w6.
    always_comb begin
        s0 = '0;
        for (int k = 0; k < 6; k++) begin
            s0[2*k +: 9] = win_sr[5-k];
        end
        s0[19] = in_num[7];
        s7 = s0;
        for (int j = 0; j < 7; j++) begin
            s7 = lfsr_step(s7);
        end
    end

    assign shadow_nxt = lfsr_step(shadow);
    assign miss_nxt   = miss_run + 3'd1;
    assign overlap_ok = (in_num[6:0] == win_sr[0][8:2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACQ;
            acq_cnt  <= '0;
            miss_run <= '0;
            shadow   <= '0;
            win_sr   <= '0;
            locked   <= 1'b0;
            mismatch <= 1'b0;
            pred_num <= '0;
            err_cnt  <= '0;
        end else begin
            mismatch <= 1'b0;
            if (clr_cnt) begin
                err_cnt <= '0;
            end
            if (in_valid) begin
                case (state)
                    ACQ: begin
                        win_sr <= {win_sr[4:0], in_num};
                        if (acq_cnt == 3'd0 || !overlap_ok) begin
                            acq_cnt <= 3'd1;
                        end else if (acq_cnt == 3'd6) begin
                            acq_cnt  <= '0;
                            miss_run <= '0;
                            shadow   <= s7;
                            pred_num <= s7[8:0];
                            locked   <= 1'b1;
                            state    <= LOCKED;
                        end else begin
                            acq_cnt <= acq_cnt + 3'd1;
                        end
                    end
                    LOCKED: begin
                        shadow   <= shadow_nxt;
                        pred_num <= shadow_nxt[8:0];
                        if (in_num != shadow[8:0]) begin
                            mismatch <= 1'b1;
                            if (!clr_cnt && err_cnt != '1) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                            if (miss_nxt == LOSS) begin
                                state    <= ACQ;
                                acq_cnt  <= '0;
                                miss_run <= '0;
                                shadow   <= '0;
                                pred_num <= '0;
                                locked   <= 1'b0;
                            end else begin
                                miss_run <= miss_nxt;
                            end
                        end else begin
                            miss_run <= '0;
                        end
                    end
                    default: state <= ACQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rand_check.sv
// Directed bench for rand_check: lock from known seeds, single and burst
// corruption, overlap break, valid gaps, async reset, and error-count saturation.
module tb_rand_check;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [8:0] in_num = '0;
    logic       clr_cnt = 1'b0;

    logic        locked, mismatch;
    logic [8:0]  pred_num;
    logic [15:0] err_cnt;
    logic        locked2, mismatch2;
    logic [8:0]  pred_num2;
    logic [3:0]  err_cnt2;

    int checks = 0;
    int errors = 0;
    logic [19:0] g;

    always #5 clk = ~clk;

    rand_check dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_num(in_num), .clr_cnt(clr_cnt),
        .locked(locked), .mismatch(mismatch), .pred_num(pred_num), .err_cnt(err_cnt)
    );

    rand_check #(.LOSS_THRESH(7), .ERR_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_num(in_num), .clr_cnt(clr_cnt),
        .locked(locked2), .mismatch(mismatch2), .pred_num(pred_num2), .err_cnt(err_cnt2)
    );

    function automatic logic [19:0] gen_step(input logic [19:0] s);
        return {s[9] ^ s[3], s[11] ^ s[2], s[19:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic v, input logic [8:0] n, input logic c);
        @(negedge clk);
        in_valid = v;
        in_num   = n;
        clr_cnt  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_true();
        send(1'b1, g[8:0], 1'b0);
        g = gen_step(g);
    endtask

    initial begin
        int bad_pulse;
        int bad_pred;
        logic [8:0] hold_pred;
        logic [15:0] hold_err;

        // Reset state
        do_reset();
        check("rst_locked", 32'(locked), 0);
        check("rst_mismatch", 32'(mismatch), 0);
        check("rst_pred", 32'(pred_num), 0);
        check("rst_err", 32'(err_cnt), 0);

        // All-ones seed: hand-computed windows 0x1FF x6, 0x0FF; S7 = 0xD003F
        for (int i = 0; i < 6; i++) send(1'b1, 9'h1FF, 1'b0);
        check("seed_not_locked_6", 32'(locked), 0);
        send(1'b1, 9'h0FF, 1'b0);
        check("seed_locked", 32'(locked), 1);
        check("seed_pred", 32'(pred_num), 32'h03F);
        g = 20'hD003F;
        send_true();
        check("seed_first_mismatch", 32'(mismatch), 0);
        check("seed_first_err", 32'(err_cnt), 0);
        check("seed_next_pred", 32'(pred_num), 32'h00F);

        bad_pulse = 0;
        bad_pred  = 0;
        for (int i = 0; i < 1000; i++) begin
            send_true();
            if (mismatch !== 1'b0) bad_pulse++;
            if (pred_num !== g[8:0]) bad_pred++;
        end
        check("clean_run_pulses", 32'(bad_pulse), 0);
        check("clean_run_preds", 32'(bad_pred), 0);
        check("clean_run_locked", 32'(locked), 1);

        // Single corrupted sample
        send(1'b1, g[8:0] ^ 9'h001, 1'b0);
        g = gen_step(g);
        check("single_pulse", 32'(mismatch), 1);
        check("single_err", 32'(err_cnt), 1);
        check("single_locked", 32'(locked), 1);
        send_true();
        check("single_pulse_done", 32'(mismatch), 0);
        check("single_still_locked", 32'(locked), 1);
        check("single_pred", 32'(pred_num), 32'(g[8:0]));

        // Clear, then three consecutive corruptions drop lock
        send(1'b0, 9'h000, 1'b1);
        check("clr_err", 32'(err_cnt), 0);
        for (int i = 1; i <= 3; i++) begin
            send(1'b1, g[8:0] ^ 9'h001, 1'b0);
            g = gen_step(g);
            check($sformatf("burst_pulse_%0d", i), 32'(mismatch), 1);
            check($sformatf("burst_err_%0d", i), 32'(err_cnt), 32'(i));
            check($sformatf("burst_locked_%0d", i), 32'(locked), (i < 3) ? 1 : 0);
        end
        check("loss_pred", 32'(pred_num), 0);
        for (int i = 0; i < 6; i++) send_true();
        check("relock_not_yet", 32'(locked), 0);
        send_true();
        check("relock", 32'(locked), 1);
        check("relock_pred", 32'(pred_num), 32'(g[8:0]));
        send_true();
        check("relock_match", 32'(mismatch), 0);

        // Overlap break: 0x0A5 does not continue 0x1FF and restarts acquisition
        do_reset();
        send(1'b1, 9'h1FF, 1'b0);
        send(1'b1, 9'h1FF, 1'b0);
        g = 20'h5A0A5;
        for (int i = 0; i < 5; i++) send_true();
        check("break_7_total", 32'(locked), 0);
        send_true();
        check("break_6_from_a5", 32'(locked), 0);
        send_true();
        check("break_locked", 32'(locked), 1);
        check("break_pred", 32'(pred_num), 32'(g[8:0]));

        // Valid gaps over a true stream
        bad_pulse = 0;
        bad_pred  = 0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                send_true();
                if (pred_num !== g[8:0]) bad_pred++;
            end else begin
                hold_pred = pred_num;
                hold_err  = err_cnt;
                send(1'b0, 9'($urandom_range(0, 511)), 1'b0);
                if (pred_num !== hold_pred || err_cnt !== hold_err) bad_pred++;
            end
            if (mismatch !== 1'b0) bad_pulse++;
        end
        check("gap_pulses", 32'(bad_pulse), 0);
        check("gap_preds", 32'(bad_pred), 0);
        check("gap_locked", 32'(locked), 1);

        // Asynchronous reset mid-lock, with a pending mismatch and nonzero count
        send(1'b1, g[8:0] ^ 9'h100, 1'b0);
        g = gen_step(g);
        check("pre_rst_err", 32'(err_cnt), 1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_locked", 32'(locked), 0);
        check("async_mismatch", 32'(mismatch), 0);
        check("async_pred", 32'(pred_num), 0);
        check("async_err", 32'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // Saturation on the 4-bit, LOSS_THRESH=7 instance
        do_reset();
        g = 20'hFFFFF;
        for (int i = 0; i < 7; i++) send_true();
        check("sat_locked", 32'(locked2), 1);
        for (int i = 0; i < 16; i++) begin
            send(1'b1, g[8:0] ^ 9'h002, 1'b0);
            g = gen_step(g);
            send_true();
        end
        check("sat_err", 32'(err_cnt2), 32'hF);
        check("sat_still_locked", 32'(locked2), 1);
        send(1'b1, g[8:0] ^ 9'h002, 1'b1);
        g = gen_step(g);
        check("sat_clr_pulse", 32'(mismatch2), 1);
        check("sat_clr_err", 32'(err_cnt2), 0);
        send_true();
        check("sat_after_clr_locked", 32'(locked2), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rand_check.md
# rand_check

Stream checker for the 20-bit, 2-bit-per-step LFSR behind the game's random-number generator (feedback fd[0]=s[11]^s[2], fd[1]=s[9]^s[3]; next state = {fd[1], fd[0], s[19:2]}; observed window = s[8:0]). The checker sits on the receiving end of the random bus. It rebuilds the full generator state from the 9-bit samples, predicts every later sample, and reports lock, per-sample mismatches and a saturating error count. Its uses are on-board self-test and the verification scoreboard.

## Interface

Parameters:
- LOSS_THRESH, 3, consecutive locked mismatches that drop lock (legal range 1..7)
- ERR_W, 16, width of err_cnt

Ports:
- clk, input, 1, single clock; all logic rising-edge
- rst, input, 1, reset; asynchronous, active-high
- in_valid, input, 1, in_num carries one generator step this cycle
- in_num, input, 9, observed window s[8:0]
- clr_cnt, input, 1, synchronous clear of err_cnt
- locked, output, 1, state reconstructed; predictions active
- mismatch, output, 1, one-cycle pulse: locked sample differed from prediction
- pred_num, output, 9, window expected on the next valid sample (0 when not locked)
- err_cnt, output, ERR_W, saturating count of locked mismatches

## Operation

- States: ACQ, LOCKED. There is no separate idle state; ACQ is entered at reset.
- Samples are consumed only when in_valid=1. While in_valid=0, state, prediction and counters hold. The generator is assumed to hold as well.
- ACQ:
  - Collect 7 samples w0..w6. A sample counter acq_cnt runs 0..6.
  - For every sample k≥1, check overlap: wk[6:0] must equal w(k-1)[8:2].
  - On overlap failure, the failing sample becomes the new w0 (acq_cnt=1).
  - On the 7th consistent sample, rebuild S0: S0[2k+8:2k] = wk for k=0..5, and S0[19] = w6[7].
  - Advance S0 seven steps to obtain the state for the next sample. Load it as the shadow register; pred_num = shadow[8:0]. Go to LOCKED.
- LOCKED:
  - Each valid sample is compared with shadow[8:0], and shadow advances one step whatever the result.
  - On mismatch: pulse mismatch, err_cnt += 1 (saturate at all-ones), miss_run += 1.
  - On match: miss_run = 0.
  - When miss_run reaches LOSS_THRESH: go to ACQ with acq_cnt=0 and discard that sample. locked=0, pred_num=0, miss_run=0.
- clr_cnt: err_cnt <= 0 next cycle. If it coincides with a mismatch, the clear wins (err_cnt=0). It does not affect state or lock.
- An all-zero rebuilt state is accepted with no special case; every later sample predicted is 0.

## Timing

- Reset values: locked=0, mismatch=0, pred_num=0, err_cnt=0, state ACQ, acq_cnt=0, miss_run=0, shadow=0.
- All outputs are registered. The response to a sample at edge N appears after edge N.
- locked rises on the cycle after the 7th consistent valid sample. pred_num becomes valid in that same cycle.
- mismatch is high for exactly one cycle, following the offending sample. Back-to-back mismatches give back-to-back pulses.
- On lock loss, locked falls in the same cycle as the final mismatch pulse.
- Minimum lock time: 7 valid cycles. After loss, reacquisition begins with the next valid sample.
- Asserting rst mid-operation clears everything immediately (asynchronous). Deassertion is used synchronously; the first valid after release is w0.

## Test plan

- Seed-all-ones stream, in_valid=1: samples 0x1FF ×6 then 0x0FF → locked=1 one cycle after the 7th, pred_num=0x03F. Next sample 0x03F → no mismatch, err_cnt=0, and 1000 further true steps stay clean.
- Locked, inject one corrupted sample (true^0x001) and then true samples → single mismatch pulse, err_cnt=1, lock held.
- LOSS_THRESH=3, three consecutive corrupted samples → three pulses, err_cnt=3, locked falls with the 3rd. Seven fresh true samples → relock.
- ACQ overlap break: 0x1FF, 0x1FF, 0x0A5, then a consistent 7-sample run from 0x0A5 → lock only after the 7th sample counted from 0x0A5.
- in_valid gaps (random 0/1 pattern) over a true stream → outputs hold during gaps, no mismatches. Pull rst mid-lock → all outputs 0 immediately.
- err_cnt with ERR_W=4: 16 mismatches with LOSS_THRESH=7 and interleaved matches → saturates at 0xF. clr_cnt asserted with a mismatch → 0.
